// File: rtl/freelist_ring_pkg.sv
// Shared constants for the rename-stage free list.
// Parameter defaults of freelist_ring are taken from here.
package freelist_ring_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int PHY_REG_SEL  = 6;
    localparam int ARCH_REG_NUM = 32;
    localparam int ISSUE_W      = 2;
    localparam int RETIRE_W     = 2;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fl_compact.sv
// Valid/data compaction with per-slot prefix counts.
// Slot i data lands at position popcount(valid[i-1:0]).
module fl_compact
    import freelist_ring_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 6
) (
    input  logic [N-1:0]          valid,
    input  logic [N*DW-1:0]       data,
    output logic [N*DW-1:0]       cdata,
    output logic [N*cnt_w(N)-1:0] prefix,
    output logic [cnt_w(N)-1:0]   count
);

    localparam int CW = cnt_w(N);

    always_comb begin
        cdata  = '0;
        prefix = '0;
        count  = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i*CW +: CW] = count;
            if (valid[i]) begin
                cdata[int'(count)*DW +: DW] = data[i*DW +: DW];
                count = count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/freelist_ring.sv
// Circular free list of physical tags with speculative and committed heads.
// A mispredict rewinds the speculative head to the committed head in one cycle.
module freelist_ring
    import freelist_ring_pkg::*;
#(
    parameter int TAG_W    = PHY_REG_SEL,
    parameter int PHY_NUM  = PHY_REG_NUM,
    parameter int ARCH_NUM = ARCH_REG_NUM,
    parameter int ALLOC_W  = ISSUE_W,
    parameter int REL_W    = RETIRE_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ALLOC_W-1:0]                    alloc_req,
    input  logic                                  stall_DP,
    input  logic                                  prmiss,
    input  logic [cnt_w(ALLOC_W)-1:0]             com_alloc_num,
    input  logic [REL_W-1:0]                      rel_valid,
    input  logic [REL_W*TAG_W-1:0]                rel_tag,
    output logic [ALLOC_W*TAG_W-1:0]              alloc_tag,
    output logic                                  allocatable,
    output logic [$clog2(PHY_NUM-ARCH_NUM):0]     freenum
);

    localparam int DEPTH = PHY_NUM - ARCH_NUM;
    localparam int IW    = $clog2(DEPTH);
    localparam int PW    = IW + 1;
    localparam int AW    = cnt_w(ALLOC_W);
    localparam int RW    = cnt_w(REL_W);

    typedef logic [PW-1:0] ptr_t;

    logic [TAG_W-1:0] ring [DEPTH];
    ptr_t spec_head, com_head, tail;
    ptr_t spec_next, com_next, tail_next;
    ptr_t wptr [REL_W];

    logic [AW-1:0]              reqnum;
    logic [ALLOC_W*AW-1:0]      req_pre;
    logic [ALLOC_W*TAG_W-1:0]   unused_alloc_data;
    logic [RW-1:0]              relnum;
    logic [REL_W*RW-1:0]        unused_rel_pre;
    logic [REL_W*TAG_W-1:0]     rel_cdata;
    logic                       fire;

    // Index wraps by subtraction so DEPTH need not be a power of two
    function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n);
        logic [IW:0] s;
        logic        w;
        s = {1'b0, p[IW-1:0]} + n;
        w = p[IW];
        if (s >= PW'(DEPTH)) begin
            s = s - PW'(DEPTH);
            w = ~w;
        end
        return {w, s[IW-1:0]};
    endfunction

    function automatic ptr_t ptr_dist(input ptr_t a, input ptr_t b);
        if (a[IW] == b[IW])
            return b - a;
        return PW'(DEPTH) - {1'b0, a[IW-1:0]} + {1'b0, b[IW-1:0]};
    endfunction

    fl_compact #(.N(ALLOC_W), .DW(TAG_W)) u_alloc_cnt (
        .valid  (alloc_req),
        .data   ('0),
        .cdata  (unused_alloc_data),
        .prefix (req_pre),
        .count  (reqnum)
    );

    fl_compact #(.N(REL_W), .DW(TAG_W)) u_rel_cmp (
        .valid  (rel_valid),
        .data   (rel_tag),
        .cdata  (rel_cdata),
        .prefix (unused_rel_pre),
        .count  (relnum)
    );

    always_comb begin
        ptr_t rp;
        rp        = '0;
        alloc_tag = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            rp = ptr_add(spec_head, PW'(req_pre[i*AW +: AW]));
            alloc_tag[i*TAG_W +: TAG_W] = ring[rp[IW-1:0]];
        end
    end

    always_comb begin
        for (int j = 0; j < REL_W; j++)
            wptr[j] = ptr_add(tail, PW'(j));
    end

    assign freenum     = ptr_dist(spec_head, tail);
    assign allocatable = (freenum >= PW'(reqnum));
    assign fire        = allocatable & ~stall_DP & ~prmiss;

    assign com_next  = ptr_add(com_head, PW'(com_alloc_num));
    assign tail_next = ptr_add(tail, PW'(relnum));

    always_comb begin
        spec_next = spec_head;
        if (prmiss)
            spec_next = com_next;
        else if (fire)
            spec_next = ptr_add(spec_head, PW'(reqnum));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spec_head <= '0;
            com_head  <= '0;
            tail      <= {1'b1, {IW{1'b0}}};
            for (int k = 0; k < DEPTH; k++)
                ring[k] <= TAG_W'(ARCH_NUM + k);
        end else begin
            spec_head <= spec_next;
            com_head  <= com_next;
            tail      <= tail_next;
            for (int j = 0; j < REL_W; j++)
                if (j < int'(relnum))
                    ring[wptr[j][IW-1:0]] <= rel_cdata[j*TAG_W +: TAG_W];
        end
    end

    // Tags are conserved, so these can only trip on a broken producer
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ptr_dist(com_head, tail) <= PW'(DEPTH));
            assert (ptr_dist(com_head, spec_head) <= ptr_dist(com_head, tail));
        end
    end

endmodule

// File: tb/tb_freelist_ring.sv
// Randomized bench for freelist_ring against a queue-based model.
// Model: queue from committed head to tail, plus speculative offset.
module tb_freelist_ring;
    import freelist_ring_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alloc_req;
    logic        stall_DP;
    logic        prmiss;
    logic [1:0]  com_alloc_num;
    logic [1:0]  rel_valid;
    logic [11:0] rel_tag;
    logic [11:0] alloc_tag;
    logic        allocatable;
    logic [5:0]  freenum;

    always #5 clk = ~clk;

    freelist_ring dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .stall_DP      (stall_DP),
        .prmiss        (prmiss),
        .com_alloc_num (com_alloc_num),
        .rel_valid     (rel_valid),
        .rel_tag       (rel_tag),
        .alloc_tag     (alloc_tag),
        .allocatable   (allocatable),
        .freenum       (freenum)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int q[$];
    int spec_off;
    bit held_b[64];
    int held_n;

    int obs_tag[2];
    int obs_free;
    int obs_alloc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pc(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 32; k++)
            q.push_back(32 + k);
        spec_off = 0;
        for (int t = 0; t < 64; t++)
            held_b[t] = (t < 32);
        held_n = 32;
    endtask

    task automatic idle_inputs();
        alloc_req     = '0;
        stall_DP      = 1'b0;
        prmiss        = 1'b0;
        com_alloc_num = '0;
        rel_valid     = '0;
        rel_tag       = '0;
    endtask

    // Reset is held with garbage on every other input
    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        alloc_req     = 2'($urandom);
        stall_DP      = 1'($urandom);
        prmiss        = 1'($urandom);
        com_alloc_num = 2'($urandom_range(0, 2));
        rel_valid     = 2'($urandom);
        rel_tag       = 12'($urandom);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic release_tag(input int t);
        q.push_back(t);
        if (held_b[t]) begin
            held_b[t] = 1'b0;
            held_n--;
        end
    endtask

    task automatic cycle(input logic [1:0] req, input logic st,
                         input logic pm, input int cn,
                         input logic [1:0] rv, input int t0,
                         input int t1);
        int  free_m;
        int  k;
        int  tg;
        bit  ok;
        @(negedge clk);
        alloc_req     = req;
        stall_DP      = st;
        prmiss        = pm;
        com_alloc_num = 2'(cn);
        rel_valid     = rv;
        rel_tag       = {6'(t1), 6'(t0)};
        #1;
        free_m = q.size() - spec_off;
        ok     = (free_m >= pc(req));
        obs_free  = int'(freenum);
        obs_alloc = int'(allocatable);
        obs_tag[0] = int'(alloc_tag[5:0]);
        obs_tag[1] = int'(alloc_tag[11:6]);
        chk("freenum", obs_free, free_m);
        chk("allocatable", obs_alloc, int'(ok));
        k = 0;
        for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
                if (spec_off + k < q.size())
                    chk($sformatf("alloc_tag%0d", i),
                        obs_tag[i], q[spec_off + k]);
                k++;
            end
        end
        @(posedge clk);
        for (int c = 0; c < cn; c++) begin
            tg = q.pop_front();
            chk("unique", int'(held_b[tg]), 0);
            held_b[tg] = 1'b1;
            held_n++;
        end
        if (pm)
            spec_off = 0;
        else
            spec_off = spec_off - cn + ((ok && !st) ? pc(req) : 0);
        if (rv[0]) release_tag(t0);
        if (rv[1]) release_tag(t1);
    endtask

    function automatic int pick(input int avoid);
        int t;
        do
            t = $urandom_range(0, 63);
        while (!held_b[t] || t == avoid);
        return t;
    endfunction

    task automatic rnd_cycle(input bit steady);
        logic [1:0] req;
        logic       st;
        logic       pm;
        int         cn;
        int         nmax;
        int         nrel;
        int         t0;
        int         t1;
        logic [1:0] rv;
        if (steady) begin
            req = 2'b11;
            st  = 1'b0;
            pm  = 1'b0;
            cn  = (spec_off < 2) ? spec_off : 2;
        end else begin
            req = 2'($urandom);
            st  = ($urandom_range(0, 7) == 0);
            pm  = ($urandom_range(0, 15) == 0);
            cn  = $urandom_range(0, (spec_off < 2) ? spec_off : 2);
        end
        nmax = held_n + cn - 32;
        if (nmax > 2) nmax = 2;
        if (nmax < 0) nmax = 0;
        nrel = steady ? nmax : $urandom_range(0, nmax);
        t0 = $urandom_range(0, 63);
        t1 = $urandom_range(0, 63);
        rv = 2'b00;
        if (nrel == 2) begin
            t0 = pick(-1);
            t1 = pick(t0);
            rv = 2'b11;
        end else if (nrel == 1) begin
            if ($urandom_range(0, 1) == 0) begin
                t0 = pick(-1);
                rv = 2'b01;
            end else begin
                t1 = pick(-1);
                rv = 2'b10;
            end
        end
        cycle(req, st, pm, cn, rv, t0, t1);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();

        // Three double allocations from reset
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
            chk("t1_free", obs_free, 32 - 2 * c);
            chk("t1_tag0", obs_tag[0], 32 + 2 * c);
            chk("t1_tag1", obs_tag[1], 33 + 2 * c);
        end
        cycle(2'b00, 0, 0, 0, 2'b00, 0, 0);
        chk("t1_free_end", obs_free, 26);

        // Unrequested slot is skipped
        do_reset();
        cycle(2'b10, 0, 0, 0, 2'b00, 0, 0);
        chk("t2_alloc", obs_alloc, 1);
        chk("t2_tag1", obs_tag[1], 32);
        cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        chk("t2_tag0b", obs_tag[0], 33);
        chk("t2_tag1b", obs_tag[1], 34);

        // Drain to empty, stall, then release into an empty list
        do_reset();
        repeat (15) cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        cycle(2'b01, 0, 0, 0, 2'b00, 0, 0);
        chk("t3_free2", obs_free, 2);
        cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        chk("t3_block", obs_alloc, 0);
        chk("t3_free1", obs_free, 1);
        cycle(2'b01, 1, 0, 0, 2'b00, 0, 0);
        chk("t3_stall_alloc", obs_alloc, 1);
        cycle(2'b01, 0, 0, 0, 2'b00, 0, 0);
        chk("t3_stall_hold", obs_free, 1);
        cycle(2'b00, 0, 0, 0, 2'b00, 0, 0);
        chk("t3_empty", obs_free, 0);
        repeat (16) cycle(2'b00, 0, 0, 2, 2'b00, 0, 0);
        cycle(2'b11, 0, 0, 0, 2'b11, 5, 9);
        chk("t3_nobypass", obs_alloc, 0);
        cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        chk("t3_rel_tag0", obs_tag[0], 5);
        chk("t3_rel_tag1", obs_tag[1], 9);

        // Mispredict rewinds to post-commit head
        do_reset();
        repeat (3) cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        cycle(2'b11, 0, 1, 2, 2'b00, 0, 0);
        cycle(2'b01, 0, 0, 0, 2'b00, 0, 0);
        chk("t4_free", obs_free, 30);
        chk("t4_tag0", obs_tag[0], 34);

        // Steady two-in two-out traffic across several wraps
        do_reset();
        rnd_cycle(1'b1);
        for (int c = 0; c < 96; c++) begin
            rnd_cycle(1'b1);
            chk("t5_steady", obs_free, 30);
        end

        // Fully random traffic
        do_reset();
        repeat (600) rnd_cycle(1'b0);

        // Reset in the middle of traffic
        repeat (20) rnd_cycle(1'b0);
        do_reset();
        cycle(2'b11, 0, 0, 0, 2'b00, 0, 0);
        chk("t7_free", obs_free, 32);
        chk("t7_tag0", obs_tag[0], 32);
        chk("t7_tag1", obs_tag[1], 33);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
